// File: rtl/kws_mul_arb_pkg.sv
// Shared widths and stage record types for the KWS multiplier arbiter.
// Stage records are sized from the package defaults, which the top uses as its parameter defaults.
package kws_mul_arb_pkg;

    localparam int NUM_REQ_DEF = 4;
    localparam int A_W_DEF     = 10;
    localparam int B_W_DEF     = 12;
    localparam int P_W_DEF     = A_W_DEF + B_W_DEF;
    localparam int ID_W_DEF    = $clog2(NUM_REQ_DEF);

    typedef struct packed {
        logic                valid;
        logic [ID_W_DEF-1:0] id;
        logic [A_W_DEF-1:0]  a;
        logic [B_W_DEF-1:0]  b;
    } stage_t;

    typedef struct packed {
        logic                valid;
        logic [ID_W_DEF-1:0] id;
        logic [P_W_DEF-1:0]  p;
    } prod_t;

endpackage

// File: rtl/kws_mul_arbiter_if.sv
// Operand request channels, product response channel and busy flag of the multiplier arbiter.
// master: requesters plus response consumer; slave: the arbiter itself.
interface kws_mul_arbiter_if
    import kws_mul_arb_pkg::*;
#(
    parameter int NUM_REQ = NUM_REQ_DEF,
    parameter int A_W     = A_W_DEF,
    parameter int B_W     = B_W_DEF,
    parameter int P_W     = P_W_DEF,
    parameter int ID_W    = $clog2(NUM_REQ)
);
    logic [NUM_REQ-1:0]     req_valid;
    logic [NUM_REQ-1:0]     req_ready;
    logic [NUM_REQ*A_W-1:0] req_a;
    logic [NUM_REQ*B_W-1:0] req_b;
    logic                   rsp_valid;
    logic                   rsp_ready;
    logic [P_W-1:0]         rsp_p;
    logic [ID_W-1:0]        rsp_id;
    logic                   busy;

    modport master (
        output req_valid, req_a, req_b, rsp_ready,
        input  req_ready, rsp_valid, rsp_p, rsp_id, busy
    );

    modport slave (
        input  req_valid, req_a, req_b, rsp_ready,
        output req_ready, rsp_valid, rsp_p, rsp_id, busy
    );
endinterface

// File: rtl/kws_mul_core.sv
// Purpose: combinational unsigned A_W x B_W full-width multiplier, kept standalone for DSP mapping.
// Latency: 0 cycles (purely combinational).
// Backpressure: none; operands come from and product goes to the arbiter's registers.
module kws_mul_core #(
    parameter int A_W = 10,
    parameter int B_W = 12,
    parameter int P_W = 22
) (
    input  logic [A_W-1:0] a,
    input  logic [B_W-1:0] b,
    output logic [P_W-1:0] p
);
    assign p = P_W'(a) * P_W'(b);
endmodule

// File: rtl/kws_mul_arbiter.sv
// Purpose: round-robin arbiter sharing one unsigned multiplier among NUM_REQ valid/ready requesters.
// Latency: accept to rsp_valid 1 cycle; 2 cycles with KWS_MUL_ARB_PIPE2_EN (extra product stage).
// Backpressure: elastic stages; a stalled response lets the stages fill, then every req_ready drops.
module kws_mul_arbiter
    import kws_mul_arb_pkg::*;
#(
    parameter int NUM_REQ = NUM_REQ_DEF,
    parameter int A_W     = A_W_DEF,
    parameter int B_W     = B_W_DEF,
    parameter int P_W     = P_W_DEF,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic             ap_clk,
    input  logic             ap_rst_n,
    kws_mul_arbiter_if.slave bus
);
    localparam logic [ID_W:0]   NUM_REQ_L = (ID_W+1)'(NUM_REQ);
    localparam logic [ID_W-1:0] LAST_IDX  = ID_W'(NUM_REQ - 1);

    logic [ID_W-1:0]    rr_ptr;
    logic [ID_W-1:0]    gnt_idx;
    logic               gnt_found;
    logic [ID_W:0]      scan_idx;
    logic [NUM_REQ-1:0] ready_vec;
    logic               s1_ready;
    logic               out_ready;
    logic               accept;
    logic               stage_busy;
    logic [P_W-1:0]     product;
    stage_t             s1_q;
    stage_t             s1_d;
    prod_t              out_src;
    prod_t              out_q;

    // First valid requester at or after rr_ptr, wrapping modulo NUM_REQ.
    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = '0;
        scan_idx  = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            scan_idx = {1'b0, rr_ptr} + (ID_W+1)'(k);
            if (scan_idx >= NUM_REQ_L) begin
                scan_idx = scan_idx - NUM_REQ_L;
            end
            if (!gnt_found && bus.req_valid[scan_idx[ID_W-1:0]]) begin
                gnt_found = 1'b1;
                gnt_idx   = scan_idx[ID_W-1:0];
            end
        end
    end

    // Ready is held off during reset so nothing can be accepted into a flushing pipe.
    assign accept = gnt_found & s1_ready & ap_rst_n;

    always_comb begin
        ready_vec = '0;
        if (accept) begin
            ready_vec[gnt_idx] = 1'b1;
        end
    end

    assign bus.req_ready = ready_vec;

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            rr_ptr <= '0;
        end else if (accept) begin
            rr_ptr <= (gnt_idx == LAST_IDX) ? '0 : gnt_idx + 1'b1;
        end
    end

    always_comb begin
        s1_d       = '0;
        s1_d.valid = accept;
        s1_d.id    = gnt_idx;
        s1_d.a     = bus.req_a[gnt_idx*A_W +: A_W];
        s1_d.b     = bus.req_b[gnt_idx*B_W +: B_W];
    end

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            s1_q <= '0;
        end else if (s1_ready) begin
            s1_q <= s1_d;
        end
    end

    kws_mul_core #(
        .A_W (A_W),
        .B_W (B_W),
        .P_W (P_W)
    ) u_mul (
        .a (s1_q.a),
        .b (s1_q.b),
        .p (product)
    );

    assign out_ready = bus.rsp_ready | ~out_q.valid;

`ifdef KWS_MUL_ARB_PIPE2_EN
    prod_t s2_q;
    logic  s2_ready;

    // Breaks the S1 -> multiplier -> output path with one more elastic register.
    assign s2_ready = ~s2_q.valid | out_ready;
    assign s1_ready = ~s1_q.valid | s2_ready;

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            s2_q <= '0;
        end else if (s2_ready) begin
            s2_q.valid <= s1_q.valid;
            if (s1_q.valid) begin
                s2_q.id <= s1_q.id;
                s2_q.p  <= product;
            end
        end
    end

    assign out_src    = s2_q;
    assign stage_busy = s1_q.valid | s2_q.valid;
`else
    assign s1_ready = ~s1_q.valid | out_ready;

    always_comb begin
        out_src       = '0;
        out_src.valid = s1_q.valid;
        out_src.id    = s1_q.id;
        out_src.p     = product;
    end

    assign stage_busy = s1_q.valid;
`endif

    // Payload only moves with a valid entry so a stalled response stays stable.
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            out_q <= '0;
        end else if (out_ready) begin
            out_q.valid <= out_src.valid;
            if (out_src.valid) begin
                out_q.id <= out_src.id;
                out_q.p  <= out_src.p;
            end
        end
    end

    assign bus.rsp_valid = out_q.valid;
    assign bus.rsp_p     = out_q.p;
    assign bus.rsp_id    = out_q.id;
    assign bus.busy      = stage_busy | out_q.valid;

endmodule

// File: tb/tb_kws_mul_arbiter.sv
// Randomized and directed bench for kws_mul_arbiter against a queue-based round-robin model.
module tb_kws_mul_arbiter;
    localparam int N = 4;
`ifdef KWS_MUL_ARB_PIPE2_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif
    localparam int DEPTH = LAT + 1;

    logic ap_clk   = 1'b0;
    logic ap_rst_n = 1'b1;
    always #5 ap_clk = ~ap_clk;

    kws_mul_arbiter_if bus ();

    kws_mul_arbiter dut (
        .ap_clk   (ap_clk),
        .ap_rst_n (ap_rst_n),
        .bus      (bus)
    );

    typedef struct {
        logic [1:0]  id;
        logic [21:0] p;
    } exp_t;

    int          total = 0;
    int          bad   = 0;
    exp_t        exp_q[$];
    int          model_ptr = 0;
    logic [N-1:0] acc_vec = '0;
    logic [9:0]  op_a [N];
    logic [11:0] op_b [N];

    assign bus.req_a = {op_a[3], op_a[2], op_a[1], op_a[0]};
    assign bus.req_b = {op_b[3], op_b[2], op_b[1], op_b[0]};

    // Reference: every accept must be the cyclic-first valid requester; responses come back in accept order.
    always @(negedge ap_clk) begin
        exp_t         e;
        int           j;
        logic [N-1:0] want;
        if (!ap_rst_n) begin
            exp_q.delete();
            model_ptr = 0;
            acc_vec   = '0;
        end else begin
            if (bus.rsp_valid === 1'b1 && bus.rsp_ready === 1'b1) begin
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL rsp_unexpected: got p=0x%h id=%0d, required no response", bus.rsp_p, bus.rsp_id);
                end else begin
                    e = exp_q.pop_front();
                    if (bus.rsp_p !== e.p || bus.rsp_id !== e.id) begin
                        bad++;
                        $display("FAIL rsp_data: got p=0x%h id=%0d, required p=0x%h id=%0d", bus.rsp_p, bus.rsp_id, e.p, e.id);
                    end
                end
            end
            acc_vec = bus.req_valid & bus.req_ready;
            if (bus.req_ready !== '0) begin
                j = -1;
                for (int k = 0; k < N; k++) begin
                    if (j < 0 && bus.req_valid[(model_ptr + k) % N]) j = (model_ptr + k) % N;
                end
                want = '0;
                if (j >= 0) want[j] = 1'b1;
                total++;
                if (bus.req_ready !== want) begin
                    bad++;
                    $display("FAIL grant: got req_ready=%b, required %b (valid=%b ptr=%0d)", bus.req_ready, want, bus.req_valid, model_ptr);
                end
                if (j >= 0) begin
                    exp_q.push_back('{id: 2'(j), p: 22'(op_a[j]) * 22'(op_b[j])});
                    model_ptr = (j + 1) % N;
                    total++;
                    if (exp_q.size() > DEPTH) begin
                        bad++;
                        $display("FAIL occupancy: got %0d in flight, required at most %0d", exp_q.size(), DEPTH);
                    end
                end
            end
        end
    end

    task automatic drive_cycle(input int p_raise, input int p_rdy);
        @(posedge ap_clk); #1;
        for (int i = 0; i < N; i++) begin
            if (acc_vec[i]) bus.req_valid[i] = 1'b0;
            if (!bus.req_valid[i] && ($urandom_range(99) < p_raise)) begin
                op_a[i] = ($urandom_range(7) == 0) ? 10'h3FF : 10'($urandom);
                op_b[i] = ($urandom_range(7) == 0) ? 12'h000 : 12'($urandom);
                bus.req_valid[i] = 1'b1;
            end
        end
        bus.rsp_ready = ($urandom_range(99) < p_rdy);
    endtask

    task automatic drain(input string tag);
        int n = 0;
        while ((bus.req_valid !== '0 || exp_q.size() != 0 || bus.busy !== 1'b0) && n < 100) begin
            drive_cycle(0, 100);
            n++;
        end
        total++;
        if (exp_q.size() != 0 || bus.busy !== 1'b0 || bus.req_valid !== '0) begin
            bad++;
            $display("FAIL drain_%s: got pending=%0d busy=%b valid=%b, required 0 0 0", tag, exp_q.size(), bus.busy, bus.req_valid);
        end
    endtask

    task automatic do_reset();
        @(posedge ap_clk); #1;
        ap_rst_n = 1'b0;
        bus.req_valid = '0;
        @(posedge ap_clk); #1;
        ap_rst_n = 1'b1;
    endtask

    task automatic test_reset();
        #1;
        ap_rst_n = 1'b0;
        bus.rsp_ready = 1'b1;
        for (int i = 0; i < N; i++) begin
            op_a[i] = 10'($urandom);
            op_b[i] = 12'($urandom);
        end
        bus.req_valid = '1;
        #10;
        total++; if (bus.rsp_valid !== 1'b0) begin bad++; $display("FAIL reset_rsp_valid: got %b, required 0", bus.rsp_valid); end
        total++; if (bus.rsp_p !== 22'h0) begin bad++; $display("FAIL reset_rsp_p: got 0x%h, required 0", bus.rsp_p); end
        total++; if (bus.rsp_id !== 2'd0) begin bad++; $display("FAIL reset_rsp_id: got %0d, required 0", bus.rsp_id); end
        total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b, required 0", bus.busy); end
        total++; if (bus.req_ready !== 4'b0000) begin bad++; $display("FAIL reset_req_ready: got %b, required 0000", bus.req_ready); end
        bus.req_valid = '0;
        @(posedge ap_clk); #1;
        ap_rst_n = 1'b1;
    endtask

    task automatic test_single_op();
        @(posedge ap_clk); #1;
        bus.rsp_ready = 1'b1;
        op_a[2] = 10'd1023;
        op_b[2] = 12'd4095;
        bus.req_valid = 4'b0100;
        @(negedge ap_clk);
        total++; if (bus.req_ready !== 4'b0100) begin bad++; $display("FAIL single_ready: got %b, required 0100", bus.req_ready); end
        @(posedge ap_clk); #1;
        bus.req_valid = '0;
        for (int k = 0; k < LAT; k++) begin
            total++; if (bus.rsp_valid !== 1'b0) begin bad++; $display("FAIL single_early: got rsp_valid=%b at +%0d, required 0", bus.rsp_valid, k); end
            @(posedge ap_clk); #1;
        end
        total++;
        if (bus.rsp_valid !== 1'b1 || bus.rsp_p !== 22'h3FEC01 || bus.rsp_id !== 2'd2) begin
            bad++;
            $display("FAIL single_rsp: got v=%b p=0x%h id=%0d, required v=1 p=0x3fec01 id=2", bus.rsp_valid, bus.rsp_p, bus.rsp_id);
        end
        total++; if (bus.busy !== 1'b1) begin bad++; $display("FAIL single_busy_hi: got %b, required 1", bus.busy); end
        @(posedge ap_clk); #1;
        total++;
        if (bus.busy !== 1'b0 || bus.rsp_valid !== 1'b0) begin
            bad++;
            $display("FAIL single_busy_lo: got busy=%b rsp_valid=%b, required 0 0", bus.busy, bus.rsp_valid);
        end
    endtask

    task automatic test_all_valid();
        do_reset();
        @(posedge ap_clk); #1;
        for (int i = 0; i < N; i++) begin
            op_a[i] = 10'(i + 1);
            op_b[i] = 12'd10;
        end
        bus.rsp_ready = 1'b1;
        bus.req_valid = '1;
        for (int c = 0; c < 8 + LAT + 1; c++) begin
            @(negedge ap_clk);
            if (c < 8) begin
                total++;
                if (bus.req_ready !== 4'(1 << (c % 4))) begin
                    bad++;
                    $display("FAIL all_grant: cycle %0d got %b, required %b", c, bus.req_ready, 4'(1 << (c % 4)));
                end
            end
            if (c >= LAT + 1) begin
                total++;
                if (bus.rsp_valid !== 1'b1 || bus.rsp_p !== 22'(10 * (((c - LAT - 1) % 4) + 1))) begin
                    bad++;
                    $display("FAIL all_product: cycle %0d got v=%b p=%0d, required v=1 p=%0d", c, bus.rsp_valid, bus.rsp_p, 10 * (((c - LAT - 1) % 4) + 1));
                end
            end
            @(posedge ap_clk); #1;
            if (c == 7) bus.req_valid = '0;
        end
        drain("all_valid");
    endtask

    task automatic test_fairness();
        do_reset();
        @(posedge ap_clk); #1;
        op_a[0] = 10'd7;
        op_b[0] = 12'd3;
        bus.req_valid = 4'b0001;
        @(posedge ap_clk); #1;
        bus.req_valid = '0;
        repeat (4) @(posedge ap_clk);
        #1;
        op_a[3] = 10'($urandom);
        op_b[3] = 12'($urandom);
        op_a[0] = 10'($urandom);
        op_b[0] = 12'($urandom);
        bus.req_valid = 4'b1001;
        @(negedge ap_clk);
        total++; if (bus.req_ready !== 4'b1000) begin bad++; $display("FAIL fair_first: got %b, required 1000", bus.req_ready); end
        @(posedge ap_clk); #1;
        bus.req_valid = 4'b0001;
        @(negedge ap_clk);
        total++; if (bus.req_ready !== 4'b0001) begin bad++; $display("FAIL fair_second: got %b, required 0001", bus.req_ready); end
        @(posedge ap_clk); #1;
        bus.req_valid = '0;
        drain("fairness");
    endtask

    task automatic test_backpressure();
        logic [21:0] hold_p;
        logic [1:0]  hold_id;
        repeat (6) drive_cycle(100, 100);
        drive_cycle(100, 0);
        @(negedge ap_clk);
        hold_p  = bus.rsp_p;
        hold_id = bus.rsp_id;
        total++; if (bus.rsp_valid !== 1'b1) begin bad++; $display("FAIL bp_valid: got %b, required 1", bus.rsp_valid); end
        for (int s = 0; s < 3; s++) begin
            drive_cycle(100, 0);
            @(negedge ap_clk);
            total++;
            if (bus.rsp_valid !== 1'b1 || bus.rsp_p !== hold_p || bus.rsp_id !== hold_id) begin
                bad++;
                $display("FAIL bp_stable: stall %0d got v=%b p=0x%h id=%0d, required v=1 p=0x%h id=%0d", s, bus.rsp_valid, bus.rsp_p, bus.rsp_id, hold_p, hold_id);
            end
            total++; if (bus.req_ready !== 4'b0000) begin bad++; $display("FAIL bp_ready: stall %0d got %b, required 0000", s, bus.req_ready); end
        end
        repeat (6) drive_cycle(100, 100);
        drain("backpressure");
    endtask

    task automatic test_zero_operand();
        int n = 0;
        @(posedge ap_clk); #1;
        bus.rsp_ready = 1'b1;
        op_a[1] = 10'd0;
        op_b[1] = 12'd4095;
        bus.req_valid = 4'b0010;
        @(posedge ap_clk); #1;
        bus.req_valid = '0;
        while (n < 10) begin
            @(negedge ap_clk);
            if (bus.rsp_valid === 1'b1) break;
            n++;
        end
        total++;
        if (n >= 10 || bus.rsp_p !== 22'h0 || bus.rsp_id !== 2'd1) begin
            bad++;
            $display("FAIL zero_operand: got v=%b p=0x%h id=%0d, required v=1 p=0 id=1", bus.rsp_valid, bus.rsp_p, bus.rsp_id);
        end
        drain("zero");
    endtask

    task automatic test_reset_mid();
        int n = 0;
        while (exp_q.size() < 2 && n < 10) begin
            drive_cycle(100, 0);
            n++;
        end
        total++; if (exp_q.size() < 2 || bus.busy !== 1'b1) begin bad++; $display("FAIL rmid_fill: got inflight=%0d busy=%b, required 2 1", exp_q.size(), bus.busy); end
        ap_rst_n = 1'b0;
        bus.req_valid = '1;
        #1;
        total++;
        if (bus.rsp_valid !== 1'b0 || bus.busy !== 1'b0 || bus.req_ready !== 4'b0000) begin
            bad++;
            $display("FAIL rmid_flush: got rsp_valid=%b busy=%b req_ready=%b, required 0 0 0000", bus.rsp_valid, bus.busy, bus.req_ready);
        end
        @(posedge ap_clk); #1;
        ap_rst_n = 1'b1;
        bus.rsp_ready = 1'b1;
        @(negedge ap_clk);
        total++; if (bus.req_ready !== 4'b0001) begin bad++; $display("FAIL rmid_ptr: got %b, required 0001", bus.req_ready); end
        total++; if (bus.rsp_valid !== 1'b0) begin bad++; $display("FAIL rmid_stale: got rsp_valid=%b, required 0", bus.rsp_valid); end
        drain("reset_mid");
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            drive_cycle(40, 70);
        end
        drain("random");
    endtask

    initial begin
        bus.req_valid = '0;
        bus.rsp_ready = 1'b0;
        for (int i = 0; i < N; i++) begin
            op_a[i] = '0;
            op_b[i] = '0;
        end
        test_reset();
        test_single_op();
        test_all_valid();
        test_fairness();
        test_backpressure();
        test_zero_operand();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion by 200000, required finish");
        $fatal(1);
    end

endmodule

// File: doc/kws_mul_arbiter.md
# kws_mul_arbiter

Round-robin arbiter and sequencer that shares one unsigned 10×12→22-bit multiplier among `NUM_REQ` requesters in the KWS accelerator datapath. Each requester uses a valid/ready operand channel. The block grants one operand pair per cycle, registers it, and drives the product and the owner's ID on a single response channel with backpressure. It sits between the feature-extraction and weight-fetch stages and the shared multiplier resource.

## Interface
Parameters:
- `NUM_REQ`, 4 — number of requesters, 2..8.
- `A_W`, 10 — operand A width, unsigned.
- `B_W`, 12 — operand B width, unsigned.
- `P_W`, 22 — product width; must equal `A_W`+`B_W`.
- `ID_W`, `$clog2(NUM_REQ)` — response ID width.

Ports:
- `ap_clk` in 1 — single clock, rising edge.
- `ap_rst_n` in 1 — asynchronous active-low reset.
- `req_valid` in `NUM_REQ` — per-requester operand valid.
- `req_ready` out `NUM_REQ` — per-requester accept; one-hot or zero.
- `req_a` in `NUM_REQ*A_W` — packed A operands; requester i is at `[i*A_W +: A_W]`.
- `req_b` in `NUM_REQ*B_W` — packed B operands; same packing.
- `rsp_valid` out 1 — product valid.
- `rsp_ready` in 1 — consumer accept.
- `rsp_p` out `P_W` — unsigned product.
- `rsp_id` out `ID_W` — index of the requester that owns `rsp_p`.
- `busy` out 1 — any pipeline stage holds valid data.

## Operation
- **Grant rule:** round-robin. The search starts at pointer `rr_ptr` (reset 0) and picks the first i, taken cyclically, with `req_valid[i]`=1.
- **Ready:** `req_ready[i]` = grant[i] & `s1_ready`. It is combinational from `req_valid`, `rr_ptr` and pipeline state.
- **Accept:** occurs when `req_valid[i]` & `req_ready[i]` at a clock edge.
  - On accept, `rr_ptr` ← (i+1) mod `NUM_REQ`.
  - With no accept, `rr_ptr` holds.
- **Stage S1:** registers `a`, `b`, `id` and `s1_valid`. `s1_ready` = !`s1_valid` | `s2_ready`.
- **Multiply:** unsigned, full width, combinational on the S1 registers. No truncation and no overflow; the maximum is 1023·4095 = 0x3FEC01.
- **Output stage:** registers `rsp_p`, `rsp_id` and `rsp_valid`, and loads when `rsp_ready` | !`rsp_valid`.
- **Stall:** when `rsp_valid`=1 and `rsp_ready`=0:
  - `rsp_p` and `rsp_id` stay stable.
  - Upstream stages fill, then all `req_ready` go to 0.
- **Simultaneous events:** accept and response-drain in the same cycle run at full throughput of one op per cycle.
- **Requester rules:** requesters must not make `req_valid` depend on `req_ready`. Once `req_valid` is asserted, it holds until accepted, with operands stable.
- **Reset:** asynchronous, including mid-operation.
  - All stages are flushed. In-flight products are discarded and never emitted.
  - `rr_ptr` ← 0.
- **Reset values:** `rsp_valid` 0, `rsp_p` 0, `rsp_id` 0, `busy` 0, `req_ready` all 0 while `ap_rst_n`=0.

## Timing
- **Latency:** accept at edge T gives `rsp_valid`=1 after edge T+1, when the pipeline is not stalled.
- **Throughput:** 1 product/cycle with `rsp_ready` held high.
- **`busy`:** registered-state OR of all stage valids. It falls the cycle after the last response handshake.
- **Critical path:** S1 → multiplier → output register. This path is the reason the configuration option below exists.

## Configuration
- **Macro:** `KWS_MUL_ARB_PIPE2_EN`.
- **Defined:**
  - An extra register stage S2 (`p`, `id`, `valid`) sits between the multiplier and the output stage, with the same elastic ready rule.
  - Latency becomes 2 (accept at T → `rsp_valid` after edge T+2).
  - Throughput remains 1/cycle.
  - Stall depth grows by one entry.
- **Undefined:** latency is 1, as above.
- **Unaffected either way:** `busy` and reset behaviour cover all present stages.

## Structure
- **Package `kws_mul_arb_pkg`:** the defaults for `A_W`, `B_W`, `P_W` and `NUM_REQ`, and a `stage_t` struct {valid, id, a/b or p}.
- **Sub-module `kws_mul_core`:** a purely combinational `A_W`×`B_W` unsigned multiplier, instantiated once. It is kept separate so synthesis can map it to a DSP48.
- **Top level:** the arbiter, pointer and elastic stages.

## Test plan
- **Single op:** only requester 2 valid, a=1023, b=4095.
  - `rsp_p`=0x3FEC01 and `rsp_id`=2, one cycle after accept (two with the macro).
  - `busy` falls after the handshake.
- **All valid:** requesters 0..3 valid continuously with a=i+1, b=10, `rsp_ready`=1.
  - Grant order is 0,1,2,3,0,…
  - Products are 10,20,30,40 back-to-back, one per cycle.
- **Fairness after skip:** `rr_ptr`=1 with only requesters 0 and 3 valid.
  - Grant goes to 3, then 0.
- **Backpressure:** `rsp_ready`=0 for 3 cycles mid-stream.
  - `rsp_p` and `rsp_id` are stable.
  - All `req_ready`=0 once full; no products are lost or duplicated after release.
- **Zero operand:** a=0, b=4095 → `rsp_p`=0.
- **Reset mid-operation:** assert `ap_rst_n`=0 with 2 ops in flight.
  - `rsp_valid`, `busy` and `req_ready` go to 0 immediately.
  - No stale product appears after release.
  - The next grant starts from requester 0.
